// File: rtl/fifo_rd_stream_adapter.sv
// Purpose: converts a FIFO pop-style read port into a registered valid/ready stream.
// Latency: 1 cycle from FIFO non-empty to O_VALID; 1 beat/cycle sustained.
// Backpressure: 2-entry skid; FIFO read request depends only on level. Optional FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN.
module fifo_rd_stream_adapter #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    output logic          O_FIFO_RD_REQ,
    input  logic [DW-1:0] I_FIFO_RD_DATA,
    input  logic          I_FIFO_RD_EMPTY,
    output logic          O_VALID,
    input  logic          I_READY,
    output logic [DW-1:0] O_DATA,
    output logic [1:0]    O_LEVEL,
    output logic [CW-1:0] O_XFER_CNT
`ifdef FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
    ,
    output logic [CW-1:0] O_STALL_CNT
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic [CW-1:0] xfer_cnt;
    logic          pop;
    logic          deq;
    logic          head_from_fifo;
    logic          head_from_tail;
    logic          tail_ld;

    // Request is a pure function of the level register, so I_READY never reaches the FIFO.
    assign O_FIFO_RD_REQ = (state != ST_TWO);
    assign O_VALID       = (state != ST_EMPTY);
    assign O_LEVEL       = state;
    assign O_DATA        = head;
    assign O_XFER_CNT    = xfer_cnt;

    assign pop = O_FIFO_RD_REQ && !I_FIFO_RD_EMPTY;
    assign deq = O_VALID && I_READY;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (pop) state_nxt = ST_ONE;
            end
            ST_ONE: begin
                if (pop && !deq)      state_nxt = ST_TWO;
                else if (!pop && deq) state_nxt = ST_EMPTY;
            end
            ST_TWO: begin
                if (deq) state_nxt = ST_ONE;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        head_from_fifo = 1'b0;
        head_from_tail = 1'b0;
        tail_ld        = 1'b0;
        case (state)
            ST_EMPTY: head_from_fifo = pop;
            ST_ONE: begin
                head_from_fifo = pop && deq;
                tail_ld        = pop && !deq;
            end
            ST_TWO:  head_from_tail = deq;
            default: ;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            head     <= '0;
            tail     <= '0;
            xfer_cnt <= '0;
        end else begin
            if (head_from_fifo)      head <= I_FIFO_RD_DATA;
            else if (head_from_tail) head <= tail;
            if (tail_ld)             tail <= I_FIFO_RD_DATA;
            if (deq)                 xfer_cnt <= xfer_cnt + CW'(1);
        end
    end

`ifdef FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;

    // Saturating so a long stall never reads back as a short one.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            stall_cnt <= '0;
        end else if (O_VALID && !I_READY && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

    assign O_STALL_CNT = stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: table vectors, corner sequences and a random
// stream against a queue-based model of FIFO contents and delivered order.
module tb_fifo_rd_stream_adapter;

    logic        clk;
    logic        rst_n;
    logic        rd_req;
    logic [7:0]  rd_data;
    logic        rd_empty;
    logic        vld;
    logic        rdy;
    logic [7:0]  dat;
    logic [1:0]  lvl;
    logic [15:0] xfer;

    logic        rst4_n;
    logic        rd_req4;
    logic [7:0]  rd_data4;
    logic        rd_empty4;
    logic        vld4;
    logic        rdy4;
    logic [7:0]  dat4;
    logic [1:0]  lvl4;
    logic [3:0]  xfer4;

`ifdef FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
    logic [15:0] stall;
    logic [3:0]  stall4;
`endif

    fifo_rd_stream_adapter #(.DW(8), .CW(16)) u_dut (
        .I_CLK           (clk),
        .I_RST_N         (rst_n),
        .O_FIFO_RD_REQ   (rd_req),
        .I_FIFO_RD_DATA  (rd_data),
        .I_FIFO_RD_EMPTY (rd_empty),
        .O_VALID         (vld),
        .I_READY         (rdy),
        .O_DATA          (dat),
        .O_LEVEL         (lvl),
        .O_XFER_CNT      (xfer)
`ifdef FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
        ,
        .O_STALL_CNT     (stall)
`endif
    );

    fifo_rd_stream_adapter #(.DW(8), .CW(4)) u_dut4 (
        .I_CLK           (clk),
        .I_RST_N         (rst4_n),
        .O_FIFO_RD_REQ   (rd_req4),
        .I_FIFO_RD_DATA  (rd_data4),
        .I_FIFO_RD_EMPTY (rd_empty4),
        .O_VALID         (vld4),
        .I_READY         (rdy4),
        .O_DATA          (dat4),
        .O_LEVEL         (lvl4),
        .O_XFER_CNT      (xfer4)
`ifdef FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
        ,
        .O_STALL_CNT     (stall4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rdy;
        logic       exp_vld;
        logic [7:0] exp_dat;
        logic [1:0] exp_lvl;
        logic       exp_req;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    // Model: q = FIFO contents, sb = words popped but not yet delivered (in order).
    logic [7:0] q[$];
    logic [7:0] sb[$];
    int         lvl_m = 0;
    int         xfer_m = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a negedge; returns at the following negedge.
    task automatic step(input logic r);
        logic pop_m;
        logic deq_m;
        rdy      = r;
        rd_empty = (q.size() == 0);
        rd_data  = (q.size() != 0) ? q[0] : 8'h00;
        #1;
        chk("rd_req", 32'(rd_req), 32'(lvl_m != 2));
        chk("valid", 32'(vld), 32'(lvl_m != 0));
        chk("level", 32'(lvl), 32'(lvl_m));
        chk("xfer_cnt", 32'(xfer), 32'(xfer_m & 16'hFFFF));
        if (lvl_m != 0 && sb.size() != 0) chk("head_data", 32'(dat), 32'(sb[0]));
        if (prev_hold) begin
            chk("stable_vld", 32'(vld), 32'd1);
            chk("stable_dat", 32'(dat), 32'(prev_dat));
        end
        pop_m = (lvl_m != 2) && (q.size() != 0);
        deq_m = (lvl_m != 0) && r;
        prev_hold = vld && !r;
        prev_dat  = dat;
        @(posedge clk);
        if (deq_m && sb.size() != 0) void'(sb.pop_front());
        if (pop_m) sb.push_back(q.pop_front());
        lvl_m  = lvl_m + int'(pop_m) - int'(deq_m);
        xfer_m = xfer_m + int'(deq_m);
        @(negedge clk);
    endtask

    task automatic tvec(input string name, input vec_t v);
        #1;
        chk({name, "_vld"}, 32'(vld), 32'(v.exp_vld));
        chk({name, "_lvl"}, 32'(lvl), 32'(v.exp_lvl));
        chk({name, "_req"}, 32'(rd_req), 32'(v.exp_req));
        if (v.exp_vld) chk({name, "_dat"}, 32'(dat), 32'(v.exp_dat));
        step(v.rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        sb.delete();
        lvl_m = 0;
        xfer_m = 0;
        prev_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t stream_tbl[10];
    vec_t bp_tbl[13];

    initial begin
        int sent;
        int n4;
        rst_n = 1'b0; rdy = 1'b0; rd_empty = 1'b1; rd_data = 8'h00;
        rst4_n = 1'b0; rdy4 = 1'b0; rd_empty4 = 1'b1; rd_data4 = 8'h3C;

        stream_tbl[0] = '{rdy: 1'b1, exp_vld: 1'b0, exp_dat: 8'h00, exp_lvl: 2'd0, exp_req: 1'b1};
        for (int i = 1; i <= 8; i++)
            stream_tbl[i] = '{rdy: 1'b1, exp_vld: 1'b1, exp_dat: 8'(i), exp_lvl: 2'd1, exp_req: 1'b1};
        stream_tbl[9] = '{rdy: 1'b1, exp_vld: 1'b0, exp_dat: 8'h00, exp_lvl: 2'd0, exp_req: 1'b1};

        bp_tbl[0] = '{rdy: 1'b0, exp_vld: 1'b0, exp_dat: 8'h00, exp_lvl: 2'd0, exp_req: 1'b1};
        bp_tbl[1] = '{rdy: 1'b0, exp_vld: 1'b1, exp_dat: 8'hA0, exp_lvl: 2'd1, exp_req: 1'b1};
        for (int i = 2; i <= 5; i++)
            bp_tbl[i] = '{rdy: 1'b0, exp_vld: 1'b1, exp_dat: 8'hA0, exp_lvl: 2'd2, exp_req: 1'b0};
        bp_tbl[6] = '{rdy: 1'b1, exp_vld: 1'b1, exp_dat: 8'hA0, exp_lvl: 2'd2, exp_req: 1'b0};
        for (int i = 7; i <= 11; i++)
            bp_tbl[i] = '{rdy: 1'b1, exp_vld: 1'b1, exp_dat: 8'(8'hA0 + i - 6), exp_lvl: 2'd1, exp_req: 1'b1};
        bp_tbl[12] = '{rdy: 1'b1, exp_vld: 1'b0, exp_dat: 8'h00, exp_lvl: 2'd0, exp_req: 1'b1};

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_data", 32'(dat), 32'h0);
        chk("reset_vld", 32'(vld), 32'h0);
        chk("reset_req", 32'(rd_req), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        rst4_n = 1'b1;

        // Idle with empty FIFO
        for (int i = 0; i < 10; i++) step($urandom_range(0, 1) == 1);

        // Streaming 0x01..0x08 with ready held high
        for (int i = 1; i <= 8; i++) q.push_back(8'(i));
        for (int i = 0; i < 10; i++) tvec("stream", stream_tbl[i]);
        chk("stream_xfer", 32'(xfer), 32'd8);

        // Backpressure 0xA0..0xA5
        for (int i = 0; i < 6; i++) q.push_back(8'(8'hA0 + i));
        for (int i = 0; i < 13; i++) begin
            tvec("bp", bp_tbl[i]);
            if (i == 5) chk("bp_two_pops", 32'(q.size()), 32'd4);
        end
        chk("bp_xfer", 32'(xfer), 32'd14);
`ifdef FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
        chk("bp_stall", 32'(stall), 32'd5);
`endif

        // Random ready against a FIFO fed 256 words with gaps
        do_reset();
        sent = 0;
        for (int cyc = 0; cyc < 6000 && xfer_m < 256; cyc++) begin
            if (sent < 256 && $urandom_range(0, 1) == 1) begin
                q.push_back(8'($urandom));
                sent++;
            end
            step($urandom_range(0, 1) == 1);
        end
        chk("rand_done", 32'(xfer_m), 32'd256);
        #1;
        chk("rand_xfer", 32'(xfer), 32'd256);
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);

        // Mid-stream reset at level 2
        do_reset();
        q.push_back(8'h10); q.push_back(8'h11); q.push_back(8'h12);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        #1;
        chk("pre_rst_lvl", 32'(lvl), 32'd2);
        chk("pre_rst_xfer", 32'(xfer), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_lvl", 32'(lvl), 32'd0);
        chk("rst_xfer", 32'(xfer), 32'd0);
        q.delete(); sb.delete();
        lvl_m = 0; xfer_m = 0; prev_hold = 1'b0;
        q.push_back(8'h55);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1);
        #1;
        chk("post_rst_vld", 32'(vld), 32'd1);
        chk("post_rst_dat", 32'(dat), 32'h55);
        step(1'b1);

        // Counter wrap on the CW=4 instance
        rd_empty4 = 1'b0;
        rdy4 = 1'b1;
        n4 = 0;
        for (int i = 0; i < 100 && n4 < 17; i++) begin
            #1;
            if (vld4 && rdy4) n4++;
            @(posedge clk);
            @(negedge clk);
        end
        rdy4 = 1'b0;
        #1;
        chk("wrap_beats", 32'(n4), 32'd17);
        chk("wrap_xfer", 32'(xfer4), 32'd1);
        chk("wrap_lvl", 32'(lvl4), 32'd1);
        for (int i = 0; i < 20; i++) @(negedge clk);
        #1;
        chk("wrap_lvl_held", 32'(lvl4), 32'd2);
        chk("wrap_req_held", 32'(rd_req4), 32'd0);
        chk("wrap_xfer_held", 32'(xfer4), 32'd1);
        chk("wrap_dat", 32'(dat4), 32'h3C);
`ifdef FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
        chk("stall_sat", 32'(stall4), 32'd15);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
